// File: rtl/elevator_scheduler.sv
// Three-floor elevator scheduler: latches floor calls, picks targets with SCAN
// ordering and sequences IDLE -> MOVE -> DOOR with registered outputs.
module elevator_scheduler #(
    parameter int MOVE_CYCLES = 4,
    parameter int DOOR_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] call,
    output logic       r1,
    output logic       r2,
    output logic       r3,
    output logic [2:0] floor,
    output logic       door_open,
    output logic       dir_up,
    output logic       busy,
    output logic [2:0] pend
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MOVE = 2'd1;
    localparam logic [1:0] DOOR = 2'd2;

    localparam int CW = $clog2(2*MOVE_CYCLES + DOOR_CYCLES + 1);
    localparam logic [CW-1:0] MV1 = CW'(MOVE_CYCLES - 1);
    localparam logic [CW-1:0] MV2 = CW'(2*MOVE_CYCLES - 1);
    localparam logic [CW-1:0] DR  = CW'(DOOR_CYCLES - 1);

    logic [1:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    target, target_n;
    logic [2:0]    rq, rq_n;
    logic [2:0]    floor_n, pend_n;
    logic          dir_n, door_n;

    logic [2:0] above, below, up_pick, dn_pick, call_eff, pn, tgt;
    logic       go_up, dist2;

    always_comb begin
        // Pending floors strictly above / below the car, nearest picked first
        above   = pend & {~floor[2], floor[0], 1'b0};
        below   = pend & {1'b0, floor[2], ~floor[0]};
        up_pick = above[1] ? 3'b010 : (above[2] ? 3'b100 : 3'b000);
        dn_pick = below[1] ? 3'b010 : (below[0] ? 3'b001 : 3'b000);
        go_up   = dir_up ? (|above) : ~(|below);
        tgt     = go_up ? up_pick : dn_pick;
        dist2   = (floor[0] & tgt[2]) | (floor[2] & tgt[0]);

        // With the door open, a call for this floor only holds the door
        call_eff = (state == DOOR) ? (call & ~floor) : call;
        pn       = pend | call_eff;

        state_n  = state;
        cnt_n    = cnt;
        target_n = target;
        rq_n     = 3'b000;
        floor_n  = floor;
        pend_n   = pn;
        dir_n    = dir_up;
        door_n   = door_open;

        case (state)
            IDLE: begin
                if (|(pn & floor)) begin
                    state_n = DOOR;
                    pend_n  = pn & ~floor;
                    cnt_n   = DR;
                    door_n  = 1'b1;
                end else if (|pend) begin
                    state_n  = MOVE;
                    target_n = tgt;
                    rq_n     = tgt;
                    dir_n    = go_up;
                    cnt_n    = dist2 ? MV2 : MV1;
                end
            end
            MOVE: begin
                if (cnt == '0) begin
                    state_n = DOOR;
                    floor_n = target;
                    pend_n  = pn & ~target;
                    cnt_n   = DR;
                    door_n  = 1'b1;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            DOOR: begin
                if (|(call & floor)) begin
                    cnt_n = DR;
                end else if (cnt == '0) begin
                    state_n = IDLE;
                    door_n  = 1'b0;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                door_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            target    <= 3'b001;
            rq        <= 3'b000;
            floor     <= 3'b001;
            pend      <= 3'b000;
            dir_up    <= 1'b1;
            door_open <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            target    <= target_n;
            rq        <= rq_n;
            floor     <= floor_n;
            pend      <= pend_n;
            dir_up    <= dir_n;
            door_open <= door_n;
            busy      <= (state_n != IDLE);
        end
    end

    assign r1 = rq[0];
    assign r2 = rq[1];
    assign r3 = rq[2];

endmodule

// File: tb/tb_elevator_scheduler.sv
// Scoreboard bench for elevator_scheduler: directed call sequences push expected
// request/arrival/door-close events; a negedge monitor pops and compares them.
module tb_elevator_scheduler;
    localparam int K_REQ = 0, K_ARR = 1, K_CLS = 2;

    typedef struct {
        int         kind;
        logic [2:0] val;
        int         aux;
        logic [2:0] pnd;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] call = 3'b000;
    logic       r1, r2, r3, door_open, dir_up, busy;
    logic [2:0] floor, pend;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_r = -1;
    int   dlen = 0;
    logic door_q = 1'b0;
    ev_t  q[$];

    elevator_scheduler #(.MOVE_CYCLES(4), .DOOR_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .call(call),
        .r1(r1), .r2(r2), .r3(r3),
        .floor(floor), .door_open(door_open), .dir_up(dir_up),
        .busy(busy), .pend(pend)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic expect_ev(input int k, input logic [2:0] v, input int aux, input logic [2:0] p);
        ev_t e;
        e.kind = k; e.val = v; e.aux = aux; e.pnd = p;
        q.push_back(e);
    endtask

    task automatic check_ev(input int k, input logic [2:0] v, input int aux, input logic [2:0] p);
        ev_t e;
        tests++;
        if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got kind=%0d val=%b aux=%0d pend=%b, required none",
                     k, v, aux, p);
        end else begin
            e = q.pop_front();
            if (e.kind != k || e.val !== v || e.aux != aux || e.pnd !== p) begin
                fails++;
                $display("FAIL event_%0d: got kind=%0d val=%b aux=%0d pend=%b, required kind=%0d val=%b aux=%0d pend=%b",
                         tests, k, v, aux, p, e.kind, e.val, e.aux, e.pnd);
            end
        end
    endtask

    // Monitor: r pulse -> request, door rising -> arrival, door falling -> close
    always @(negedge clk) begin
        if (rst) begin
            door_q = 1'b0;
            last_r = -1;
        end else begin
            if (r1 | r2 | r3) begin
                check_ev(K_REQ, {r3, r2, r1}, int'(dir_up), pend);
                last_r = cyc;
            end
            if (door_open && !door_q) begin
                check_ev(K_ARR, floor, (last_r < 0) ? 0 : cyc - last_r, pend);
                last_r = -1;
                dlen = 0;
            end
            if (door_open) dlen++;
            if (!door_open && door_q) check_ev(K_CLS, floor, dlen, pend);
            door_q = door_open;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic press(input logic [2:0] c, input int n);
        call = c;
        repeat (n) @(posedge clk);
        #1 call = 3'b000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || pend != 3'b000 || door_open) && n < budget) begin
            @(posedge clk);
            #1 n++;
        end
        tests++;
        if (n >= budget) begin
            fails++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_door(input int budget);
        int n = 0;
        while (!door_open && n < budget) begin
            @(posedge clk);
            #1 n++;
        end
        tests++;
        if (n >= budget) begin
            fails++;
            $display("FAIL wait_door: door still closed after %0d cycles, required open", n);
        end
    endtask

    initial begin
        // Reset with every call held: calls must be ignored on reset edges
        rst = 1'b1;
        call = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_floor", int'(floor), 1);
        chk("rst_pend", int'(pend), 0);
        chk("rst_flags", int'({dir_up, busy, door_open, r3, r2, r1}), 6'b100000);
        call = 3'b000;
        rst = 1'b0;

        // Single call to F3 from F1
        expect_ev(K_REQ, 3'b100, 1, 3'b100);
        expect_ev(K_ARR, 3'b100, 8, 3'b000);
        expect_ev(K_CLS, 3'b100, 3, 3'b000);
        press(3'b100, 1);
        chk("s2_pend_latched", int'(pend), 4);
        chk("s2_busy_before_move", int'(busy), 0);
        @(posedge clk);
        #1 chk("s2_busy_moving", int'(busy), 1);
        wait_idle(60);
        chk("s2_floor_end", int'(floor), 4);

        // From F2 going up with F1 and F3 pending: F3 first, then reverse to F1
        do_reset();
        expect_ev(K_REQ, 3'b010, 1, 3'b010);
        expect_ev(K_ARR, 3'b010, 4, 3'b000);
        expect_ev(K_CLS, 3'b010, 3, 3'b101);
        expect_ev(K_REQ, 3'b100, 1, 3'b101);
        expect_ev(K_ARR, 3'b100, 4, 3'b001);
        expect_ev(K_CLS, 3'b100, 3, 3'b001);
        expect_ev(K_REQ, 3'b001, 0, 3'b001);
        expect_ev(K_ARR, 3'b001, 8, 3'b000);
        expect_ev(K_CLS, 3'b001, 3, 3'b000);
        press(3'b010, 1);
        wait_door(40);
        press(3'b101, 1);
        wait_idle(100);
        chk("s3_dir_down", int'(dir_up), 0);

        // At F1 heading down with F2+F3 called: reverses up, F2 then F3
        expect_ev(K_REQ, 3'b010, 1, 3'b110);
        expect_ev(K_ARR, 3'b010, 4, 3'b100);
        expect_ev(K_CLS, 3'b010, 3, 3'b100);
        expect_ev(K_REQ, 3'b100, 1, 3'b100);
        expect_ev(K_ARR, 3'b100, 4, 3'b000);
        expect_ev(K_CLS, 3'b100, 3, 3'b000);
        press(3'b110, 1);
        wait_idle(100);

        // Call for F1 arriving during the move to F3 is latched, served afterwards
        do_reset();
        expect_ev(K_REQ, 3'b100, 1, 3'b100);
        expect_ev(K_ARR, 3'b100, 8, 3'b001);
        expect_ev(K_CLS, 3'b100, 3, 3'b001);
        expect_ev(K_REQ, 3'b001, 0, 3'b001);
        expect_ev(K_ARR, 3'b001, 8, 3'b000);
        expect_ev(K_CLS, 3'b001, 3, 3'b000);
        press(3'b100, 1);
        @(posedge clk);
        #1 press(3'b001, 1);
        chk("s5_pend_mid_move", int'(pend), 5);
        wait_idle(100);

        // Door at current floor held open by repeated call, no request pulse
        expect_ev(K_ARR, 3'b001, 0, 3'b000);
        expect_ev(K_CLS, 3'b001, 6, 3'b000);
        press(3'b001, 1);
        @(posedge clk);
        #1 press(3'b001, 2);
        chk("s6_pend_door_call", int'(pend), 0);
        wait_idle(40);

        // Reset mid-move with F1 and F2 pending abandons everything
        expect_ev(K_REQ, 3'b010, 1, 3'b010);
        press(3'b010, 1);
        @(posedge clk);
        #1 press(3'b001, 1);
        chk("s7_pend_before_rst", int'(pend), 3);
        do_reset();
        chk("s7_floor", int'(floor), 1);
        chk("s7_pend", int'(pend), 0);
        chk("s7_flags", int'({busy, door_open, r3, r2, r1}), 0);
        repeat (10) @(posedge clk);
        #1 chk("s7_floor_settled", int'(floor), 1);
        chk("s7_busy_settled", int'(busy), 0);

        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
